// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter sharing one synchronous sprite/background ROM
// between N_REQ pixel-fetch requesters, with tagged fixed-latency return.
module sprite_rom_arbiter #(
  parameter int N_REQ  = 4,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 4,
  localparam int IDX_W = $clog2(N_REQ)
) (
  input  logic                    vga_clk,
  input  logic                    reset_n,
  input  logic                    frame_start,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*ADDR_W-1:0] addr,
  output logic [N_REQ-1:0]        gnt,
  output logic [ADDR_W-1:0]       rom_address,
  input  logic [DATA_W-1:0]       rom_q,
  output logic [N_REQ-1:0]        rvalid,
  output logic [IDX_W-1:0]        rid,
  output logic [DATA_W-1:0]       rdata
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);
  localparam logic [N_REQ-1:0] ONE = N_REQ'(1);

  logic [IDX_W-1:0]  r_last;
  logic [ADDR_W-1:0] r_rom_address;
  logic              r_v1;
  logic              r_v2;
  logic [IDX_W-1:0]  r_id1;
  logic [IDX_W-1:0]  r_id2;

  logic              w_any;
  logic [IDX_W-1:0]  w_win;
  logic [ADDR_W-1:0] w_addr [N_REQ];

  for (genvar g = 0; g < N_REQ; g++) begin : g_addr
    assign w_addr[g] = addr[g*ADDR_W +: ADDR_W];
  end

  // Search from last+1 upward, wrapping; first requester found wins.
  always_comb begin : p_grant
    int j;
    w_any = 1'b0;
    w_win = '0;
    j     = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      j = (int'(r_last) + k) % N_REQ;
      if (!w_any && req[j]) begin
        w_any = 1'b1;
        w_win = IDX_W'(j);
      end
    end
    if (!reset_n) begin
      w_any = 1'b0;
    end
  end

  assign gnt = w_any ? (ONE << w_win) : '0;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last        <= LAST_IDX;
      r_rom_address <= '0;
      r_v1          <= 1'b0;
      r_v2          <= 1'b0;
      r_id1         <= '0;
      r_id2         <= '0;
    end else begin
      r_v1  <= w_any;
      r_v2  <= r_v1;
      r_id2 <= r_id1;
      if (w_any) begin
        r_rom_address <= w_addr[w_win];
        r_id1         <= w_win;
        r_last        <= w_win;
      end
      // Frame re-seed wins over the winner update at the same edge.
      if (frame_start) begin
        r_last <= LAST_IDX;
      end
    end
  end

  assign rom_address = r_rom_address;
  assign rvalid      = r_v2 ? (ONE << r_id2) : '0;
  assign rid         = r_id2;
  assign rdata       = rom_q;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed self-checking bench for sprite_rom_arbiter
// with a behavioural synchronous ROM.
module tb_sprite_rom_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        frame_start;
  logic [3:0]  req;
  logic [39:0] addr;
  logic [3:0]  gnt;
  logic [9:0]  rom_address;
  logic [3:0]  rom_q;
  logic [3:0]  rvalid;
  logic [1:0]  rid;
  logic [3:0]  rdata;

  int n_chk = 0;
  int n_err = 0;

  sprite_rom_arbiter #(
    .N_REQ(4), .ADDR_W(10), .DATA_W(4)
  ) dut (
    .vga_clk     (clk),
    .reset_n     (reset_n),
    .frame_start (frame_start),
    .req         (req),
    .addr        (addr),
    .gnt         (gnt),
    .rom_address (rom_address),
    .rom_q       (rom_q),
    .rvalid      (rvalid),
    .rid         (rid),
    .rdata       (rdata)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] rom_fn(input logic [9:0] a);
    return a[3:0] ^ a[7:4] ^ {2'b00, a[9:8]};
  endfunction

  always @(posedge clk) rom_q <= rom_fn(rom_address);

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [9:0] fa [4];

  initial begin
    reset_n     = 1'b0;
    frame_start = 1'b0;
    req         = 4'hF;
    addr        = '0;
    #2;
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_rvalid", rvalid, 4'b0000);
    chk("rst_rid", rid, 2'd0);
    chk("rst_addr", rom_address, 10'h000);
    @(negedge clk);
    reset_n = 1'b1;
    req     = 4'b0000;

    // single request
    req = 4'b0100;
    addr[20 +: 10] = 10'h155;
    #1;
    chk("t1_gnt", gnt, 4'b0100);
    tick();
    req = 4'b0000;
    chk("t1_addr", rom_address, 10'h155);
    chk("t1_rvalid_e0", rvalid, 4'b0000);
    tick();
    chk("t1_rvalid", rvalid, 4'b0100);
    chk("t1_rid", rid, 2'd2);
    chk("t1_rdata", rdata, rom_fn(10'h155));

    // full load from reset
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("t2_rst_rvalid", rvalid, 4'b0000);
    fa[0] = 10'h101; fa[1] = 10'h0B2;
    fa[2] = 10'h3E7; fa[3] = 10'h24C;
    for (int i = 0; i < 4; i++) addr[i*10 +: 10] = fa[i];
    @(negedge clk);
    reset_n = 1'b1;
    req     = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("t2_gnt%0d", k), gnt, 4'b0001 << (k % 4));
      @(posedge clk);
      #1;
      chk($sformatf("t2_addr%0d", k), rom_address, fa[k % 4]);
      if (k >= 1) begin
        chk($sformatf("t2_rvalid%0d", k), rvalid,
            4'b0001 << ((k - 1) % 4));
        chk($sformatf("t2_rid%0d", k), rid, (k - 1) % 4);
        chk($sformatf("t2_rdata%0d", k), rdata,
            rom_fn(fa[(k - 1) % 4]));
      end
    end
    req = 4'b0000;

    // wrap-around from last=1
    req = 4'b0010;
    #1;
    chk("t3_seed_gnt", gnt, 4'b0010);
    tick();
    req = 4'b1010;
    #1;
    chk("t3_gnt_a", gnt, 4'b1000);
    tick();
    chk("t3_gnt_b", gnt, 4'b0010);
    tick();
    req = 4'b1111;
    #1;
    chk("t3_last1", gnt, 4'b0100);

    // frame_start with simultaneous acceptance, last=0
    req = 4'b0001;
    #1;
    chk("t4_seed_gnt", gnt, 4'b0001);
    tick();
    req         = 4'b0111;
    frame_start = 1'b1;
    #1;
    chk("t4_gnt_fs", gnt, 4'b0010);
    tick();
    frame_start = 1'b0;
    chk("t4_addr", rom_address, fa[1]);
    #1;
    chk("t4_gnt_next", gnt, 4'b0001);
    req = 4'b0000;

    // idle after read of 2A0
    addr[0 +: 10] = 10'h2A0;
    req = 4'b0001;
    #1;
    chk("t5_gnt_acc", gnt, 4'b0001);
    tick();
    req = 4'b0000;
    for (int n = 1; n <= 5; n++) begin
      #1;
      chk($sformatf("t5_gnt%0d", n), gnt, 4'b0000);
      chk($sformatf("t5_addr%0d", n), rom_address, 10'h2A0);
      if (n >= 3)
        chk($sformatf("t5_rvalid%0d", n), rvalid, 4'b0000);
      else if (n == 2)
        chk("t5_rvalid_read", rvalid, 4'b0001);
      tick();
    end
    req = 4'b1111;
    #1;
    chk("t5_last_kept", gnt, 4'b0010);
    req = 4'b0000;

    // reset mid-flight
    addr[30 +: 10] = 10'h3C3;
    req = 4'b1000;
    #1;
    chk("t6_gnt", gnt, 4'b1000);
    tick();
    req = 4'b0000;
    chk("t6_addr", rom_address, 10'h3C3);
    #1;
    reset_n = 1'b0;
    #1;
    chk("t6_addr_rst", rom_address, 10'h000);
    chk("t6_gnt_rst", gnt, 4'b0000);
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    chk("t6_rvalid_e1", rvalid, 4'b0000);
    tick();
    chk("t6_rvalid_e2", rvalid, 4'b0000);
    req = 4'b1111;
    #1;
    chk("t6_first_gnt", gnt, 4'b0001);
    req = 4'b0000;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/sprite_rom_arbiter.md
# sprite_rom_arbiter

Round-robin arbiter that shares one synchronous sprite/background ROM (`ex6_rom`-style: address sampled on `vga_clk`, `q` valid after that edge) between up to `N_REQ` pixel-fetch requesters: background tiler, tanks and bullets. It sits between the per-object draw logic and the single ROM instance, issuing at most one ROM read per clock. It returns each read's data, tagged to its requester, with fixed latency. The palette lookup downstream is unchanged; it consumes `rdata` in place of raw `rom_q`.

## Interface

Parameters:
- `N_REQ`, default 4: number of requesters, range 2..8.
- `ADDR_W`, default 10: ROM address width.
- `DATA_W`, default 4: ROM word width (palette index).

Ports:
- `vga_clk`, in, 1: the single clock; all state updates on its rising edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `frame_start`, in, 1: one-cycle pulse at the start of a frame; re-seeds round-robin priority.
- `req`, in, `N_REQ`: per-requester read request; level, held until granted.
- `addr`, in, `N_REQ*ADDR_W`: flattened addresses; requester i uses bits `[i*ADDR_W +: ADDR_W]`. Must be stable while `req[i]`=1.
- `gnt`, out, `N_REQ`: combinational one-hot grant. Request i is accepted at the edge where `req[i]&gnt[i]`=1.
- `rom_address`, out, `ADDR_W`: registered address to the ROM.
- `rom_q`, in, `DATA_W`: ROM read data.
- `rvalid`, out, `N_REQ`: one-hot, registered; marks the cycle in which `rdata` belongs to requester i.
- `rid`, out, `$clog2(N_REQ)`: binary index of the requester owning `rdata`. Meaningful only when `|rvalid`.
- `rdata`, out, `DATA_W`: pass-through of `rom_q`.

## Operation

- **Pointer:** `last` (`$clog2(N_REQ)` bits) holds the index of the most recent accepted requester.
  - Search order starts at `last+1` and proceeds modulo `N_REQ`, wrapping from `N_REQ-1` to 0.
- **Grant:** `gnt` is one-hot for the first requester in search order with `req` high. It is all-zero if no `req` bit is set.
  - Any acceptance updates `last` to the winner's index.
- **Address:** on acceptance, `rom_address <= addr[winner]`. With no acceptance, `rom_address` holds its value and no new read is tagged.
- **Return pipeline:** two tag stages track each read.
  - Stage 1 (`v1`, `id1`) is registered at the acceptance edge.
  - Stage 2 drives `rvalid` and `rid`; it is registered from stage 1 at the next edge.
  - `rvalid = onehot(id2)` when `v2`=1, else 0.
- **Read data:** `rdata = rom_q`, combinational, no extra register.
- **`frame_start`:** at an edge with `frame_start`=1, `last <= N_REQ-1`, so requester 0 has top priority next cycle.
  - This overrides the winner update at the same edge.
  - The acceptance itself (grant, `rom_address`, tags) still proceeds using the pre-edge priority.
- **Throughput:** one accepted read per cycle sustained. With all requesters active, each requester is served exactly once per `N_REQ` cycles.
- **Reset (`reset_n`=0, asynchronous):**
  - `last`=`N_REQ-1`, `rom_address`=0.
  - `v1`=`v2`=0, `id1`=`id2`=0, so `rvalid`=0 and `rid`=0.
  - `gnt` is forced to 0 while `reset_n`=0.
  - Reads in flight are dropped; no `rvalid` is produced for them after release.

## Timing

- **Acceptance:** occurs at edge E0 (the edge where `req[i]&gnt[i]`=1).
- **After E0:** `rom_address` = `addr[i]`. The ROM samples this address at E1.
- **After E1:** `rom_q` valid and `rvalid[i]`=1, `rid`=i, `rdata`=`ROM[addr[i]]`. The requester captures at E2.
- **Latency:** 2 edges from acceptance to `rvalid`, fixed and independent of load.
- **Requester handshake:** the requester may keep `req` high after acceptance to issue the next read. It must change `addr` in the cycle after acceptance if a different address is wanted. A held `req` with an unchanged `addr` produces a repeat read.
- **`gnt` timing:** `gnt` depends on `req` and `last` only; there is no combinational path from `addr` or `rom_q` to `gnt`.
- **Release from reset:** first acceptance possible at the first edge after `reset_n` rises. Requester 0 wins any contention there.

## Test plan

1. **Single request:** reset, then `req`=`4'b0100`, `addr[2]`=`10'h155`.
   - `gnt`=`4'b0100` in the same cycle; `rom_address`=`10'h155` after E0.
   - `rvalid`=`4'b0100`, `rid`=2, `rdata`=`model[10'h155]` after E1.
2. **Full load:** all `req` high continuously from reset, distinct addresses.
   - Grant order 0,1,2,3,0,1…, one per cycle.
   - `rvalid`/`rid` follow the same order 2 cycles later, with data matching each address.
3. **Wrap-around:** `last`=1, `req`=`4'b1010`.
   - `gnt`=`4'b1000` (3 wins); the next cycle `gnt`=`4'b0010`; `last`=1 afterwards.
4. **`frame_start` with simultaneous acceptance:** `last`=0, `req`=`4'b0111`, `frame_start`=1.
   - Requester 1 is accepted at that edge and `last`=3 afterwards.
   - The next cycle, requester 0 is granted.
5. **Idle:** `req`=0 for 5 cycles after a read of `10'h2A0`.
   - `gnt`=0, `rom_address` stays `10'h2A0`, `rvalid`=0 from the third idle cycle on, `last` unchanged.
6. **Reset mid-flight:** accept at E0, pulse `reset_n` low between E0 and E1.
   - `rvalid` is never asserted for that read; `rom_address`=0 immediately.
   - After release, with `req`=`4'b1111`, requester 0 is granted first.
